// File: rtl/trap_pkg.sv
// Shared types and helpers for the machine-mode interrupt entry / mret sequencer.
// The cause-code defaults match the standard RISC-V interrupt numbering.
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRAP_JUMP = 2'd1,
        RET_JUMP  = 2'd2
    } trap_state_e;

    localparam int         MCAUSE_INT_BIT  = 31;
    localparam logic [4:0] DEF_TIMER_CAUSE = 5'd7;
    localparam logic [4:0] DEF_EXT_CAUSE   = 5'd11;

    function automatic logic [31:0] make_mcause(input logic [4:0] code);
        logic [31:0] m;
        m                 = '0;
        m[MCAUSE_INT_BIT] = 1'b1;
        m[4:0]            = code;
        return m;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Masked interrupt priority encoder: external beats timer.
// Global enable is handled by the caller so this stays purely per-source.
module irq_prio_enc
    import trap_pkg::*;
#(
    parameter logic [4:0] TIMER_CAUSE = DEF_TIMER_CAUSE,
    parameter logic [4:0] EXT_CAUSE   = DEF_EXT_CAUSE
) (
    input  logic       irq_timer,
    input  logic       irq_ext,
    input  logic       mie_timer,
    input  logic       mie_ext,
    output logic       irq_any,
    output logic [4:0] code
);

    logic irq_t;
    logic irq_e;

    assign irq_t = irq_timer & mie_timer;
    assign irq_e = irq_ext & mie_ext;

    always_comb begin
        irq_any = irq_t | irq_e;
        code    = 5'd0;
        if (irq_e) begin
            code = EXT_CAUSE;
        end else if (irq_t) begin
            code = TIMER_CAUSE;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Interrupt entry and mret return sequencer beside the execute stage.
// Detect cycle strobes CSRs and kills EX; the following cycle redirects the PC.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter bit         VECTORED    = 1'b0,
    parameter logic [4:0] TIMER_CAUSE = DEF_TIMER_CAUSE,
    parameter logic [4:0] EXT_CAUSE   = DEF_EXT_CAUSE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        irq_timer,
    input  logic        irq_ext,
    input  logic        mie_global,
    input  logic        mie_timer,
    input  logic        mie_ext,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        br_true,
    input  logic        jump_en,
    input  logic        mret_req,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc_csr,
    output logic        epc_taken,
    output logic [31:0] epc,
    output logic        stall,
    output logic        flush,
    output logic        mepc_we,
    output logic [31:0] mepc_wdata,
    output logic        mcause_we,
    output logic [31:0] mcause_wdata,
    output logic        mie_clear,
    output logic        mie_restore,
    output logic        busy
);

    trap_state_e state_q, state_d;
    logic [31:0] target_q, target_d;

    logic        irq_any;
    logic [4:0]  irq_code;
    logic        take_irq;
    logic [31:0] trap_base;
    logic [31:0] trap_target;
    logic [31:0] ret_target;

    irq_prio_enc #(
        .TIMER_CAUSE (TIMER_CAUSE),
        .EXT_CAUSE   (EXT_CAUSE)
    ) u_prio (
        .irq_timer (irq_timer),
        .irq_ext   (irq_ext),
        .mie_timer (mie_timer),
        .mie_ext   (mie_ext),
        .irq_any   (irq_any),
        .code      (irq_code)
    );

    // Branch/jump cycles defer the interrupt so the redirect never collides.
    assign take_irq = mie_global & irq_any & ex_valid & ~br_true & ~jump_en;

    assign trap_base  = mtvec & 32'hFFFF_FFFC;
    assign ret_target = mepc_csr & 32'hFFFF_FFFC;

    always_comb begin
        trap_target = trap_base;
        if (VECTORED) begin
            trap_target = trap_base + {25'd0, irq_code, 2'b00};
        end
    end

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        epc_taken    = 1'b0;
        epc          = 32'h0;
        stall        = 1'b0;
        flush        = 1'b0;
        mepc_we      = 1'b0;
        mepc_wdata   = 32'h0;
        mcause_we    = 1'b0;
        mcause_wdata = 32'h0;
        mie_clear    = 1'b0;
        mie_restore  = 1'b0;
        busy         = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                // Held reset must not leak strobes from a pending interrupt.
                if (rst_n && take_irq) begin
                    mepc_we      = 1'b1;
                    mepc_wdata   = ex_pc;
                    mcause_we    = 1'b1;
                    mcause_wdata = make_mcause(irq_code);
                    mie_clear    = 1'b1;
                    stall        = 1'b1;
                    flush        = 1'b1;
                    target_d     = trap_target;
                    state_d      = TRAP_JUMP;
                end else if (rst_n && mret_req && ex_valid) begin
                    stall    = 1'b1;
                    flush    = 1'b1;
                    target_d = ret_target;
                    state_d  = RET_JUMP;
                end
            end
            TRAP_JUMP: begin
                epc_taken = 1'b1;
                epc       = target_q;
                flush     = 1'b1;
                state_d   = IDLE;
            end
            RET_JUMP: begin
                epc_taken   = 1'b1;
                epc         = target_q;
                flush       = 1'b1;
                mie_restore = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Target is pure data; it is only observed while state is a jump state.
    always_ff @(posedge clk) begin
        target_q <= target_d;
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench: directed stimulus pushes per-cycle expectations for a
// non-vectored and a vectored instance; a negedge monitor pops and compares.
module tb_trap_ctrl;

    typedef struct packed {
        logic        epc_taken;
        logic [31:0] epc;
        logic        stall;
        logic        flush;
        logic        mepc_we;
        logic [31:0] mepc_wdata;
        logic        mcause_we;
        logic [31:0] mcause_wdata;
        logic        mie_clear;
        logic        mie_restore;
        logic        busy;
    } out_t;

    typedef struct packed {
        logic [15:0] tag;
        out_t        v0;
        out_t        v1;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        irq_timer, irq_ext, mie_global, mie_timer, mie_ext;
    logic        ex_valid, br_true, jump_en, mret_req;
    logic [31:0] ex_pc, mtvec, mepc_csr;

    out_t act0, act1;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    trap_ctrl #(.VECTORED(1'b0)) dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_timer    (irq_timer),
        .irq_ext      (irq_ext),
        .mie_global   (mie_global),
        .mie_timer    (mie_timer),
        .mie_ext      (mie_ext),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .br_true      (br_true),
        .jump_en      (jump_en),
        .mret_req     (mret_req),
        .mtvec        (mtvec),
        .mepc_csr     (mepc_csr),
        .epc_taken    (act0.epc_taken),
        .epc          (act0.epc),
        .stall        (act0.stall),
        .flush        (act0.flush),
        .mepc_we      (act0.mepc_we),
        .mepc_wdata   (act0.mepc_wdata),
        .mcause_we    (act0.mcause_we),
        .mcause_wdata (act0.mcause_wdata),
        .mie_clear    (act0.mie_clear),
        .mie_restore  (act0.mie_restore),
        .busy         (act0.busy)
    );

    trap_ctrl #(.VECTORED(1'b1)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_timer    (irq_timer),
        .irq_ext      (irq_ext),
        .mie_global   (mie_global),
        .mie_timer    (mie_timer),
        .mie_ext      (mie_ext),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .br_true      (br_true),
        .jump_en      (jump_en),
        .mret_req     (mret_req),
        .mtvec        (mtvec),
        .mepc_csr     (mepc_csr),
        .epc_taken    (act1.epc_taken),
        .epc          (act1.epc),
        .stall        (act1.stall),
        .flush        (act1.flush),
        .mepc_we      (act1.mepc_we),
        .mepc_wdata   (act1.mepc_wdata),
        .mcause_we    (act1.mcause_we),
        .mcause_wdata (act1.mcause_wdata),
        .mie_clear    (act1.mie_clear),
        .mie_restore  (act1.mie_restore),
        .busy         (act1.busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t o_idle();
        out_t o;
        o = '0;
        return o;
    endfunction

    function automatic out_t o_entry(input logic [31:0] pc, input logic [31:0] cause);
        out_t o;
        o = '0;
        o.mepc_we      = 1'b1;
        o.mepc_wdata   = pc;
        o.mcause_we    = 1'b1;
        o.mcause_wdata = cause;
        o.mie_clear    = 1'b1;
        o.stall        = 1'b1;
        o.flush        = 1'b1;
        return o;
    endfunction

    function automatic out_t o_mret();
        out_t o;
        o = '0;
        o.stall = 1'b1;
        o.flush = 1'b1;
        return o;
    endfunction

    function automatic out_t o_jump(input logic [31:0] tgt, input logic ret);
        out_t o;
        o = '0;
        o.epc_taken   = 1'b1;
        o.epc         = tgt;
        o.flush       = 1'b1;
        o.mie_restore = ret;
        o.busy        = 1'b1;
        return o;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                         input logic mr, input logic it, input logic ie, input logic mg);
        ex_valid   = v;
        ex_pc      = pc;
        br_true    = br;
        jump_en    = jmp;
        mret_req   = mr;
        irq_timer  = it;
        irq_ext    = ie;
        mie_global = mg;
    endtask

    // Inputs for the cycle are already applied; record expectation and advance.
    task automatic step(input int tag, input out_t e0, input out_t e1);
        exp_t e;
        e.tag = tag[15:0];
        e.v0  = e0;
        e.v1  = e1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks = n_checks + 1;
            if (act0 !== e.v0) begin
                n_fail = n_fail + 1;
                $display("FAIL step%0d_novec actual=%h required=%h", e.tag, act0, e.v0);
            end
            n_checks = n_checks + 1;
            if (act1 !== e.v1) begin
                n_fail = n_fail + 1;
                $display("FAIL step%0d_vec actual=%h required=%h", e.tag, act1, e.v1);
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        mie_timer = 1'b1;
        mie_ext   = 1'b1;
        mtvec     = 32'h200;
        mepc_csr  = 32'h0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Reset held with an enabled pending interrupt: everything quiet.
        drive(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1, o_idle(), o_idle());
        rst_n = 1'b1;
        drive(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(2, o_idle(), o_idle());

        // Timer interrupt.
        mtvec = 32'h200;
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(3, o_entry(32'h100, 32'h8000_0007), o_entry(32'h100, 32'h8000_0007));
        drive(1'b0, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(4, o_jump(32'h200, 1'b0), o_jump(32'h21C, 1'b0));
        drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(5, o_idle(), o_idle());

        // External and timer together; low mtvec bits are ignored.
        mtvec = 32'h1003;
        drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(6, o_entry(32'h300, 32'h8000_000B), o_entry(32'h300, 32'h8000_000B));
        drive(1'b0, 32'h304, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(7, o_jump(32'h1000, 1'b0), o_jump(32'h102C, 1'b0));

        // Interrupt deferred by a branch, then by a jump, then by a bubble.
        mtvec = 32'h1000;
        drive(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(8, o_idle(), o_idle());
        drive(1'b1, 32'h440, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(9, o_idle(), o_idle());
        drive(1'b0, 32'h444, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(10, o_idle(), o_idle());
        drive(1'b1, 32'h480, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(11, o_entry(32'h480, 32'h8000_0007), o_entry(32'h480, 32'h8000_0007));
        drive(1'b0, 32'h484, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(12, o_jump(32'h1000, 1'b0), o_jump(32'h101C, 1'b0));

        // mret, with an interrupt pending that is taken right after return.
        mepc_csr = 32'h104;
        drive(1'b0, 32'h900, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(13, o_idle(), o_idle());
        drive(1'b1, 32'h900, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(14, o_mret(), o_mret());
        drive(1'b0, 32'h904, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(15, o_jump(32'h104, 1'b1), o_jump(32'h104, 1'b1));
        drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(16, o_entry(32'h104, 32'h8000_0007), o_entry(32'h104, 32'h8000_0007));
        drive(1'b0, 32'h108, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(17, o_jump(32'h1000, 1'b0), o_jump(32'h101C, 1'b0));
        drive(1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(18, o_idle(), o_idle());

        // mret and interrupt in the same cycle: trap wins, no restore.
        mepc_csr = 32'h777;
        drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(19, o_entry(32'h500, 32'h8000_000B), o_entry(32'h500, 32'h8000_000B));
        drive(1'b0, 32'h504, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(20, o_jump(32'h1000, 1'b0), o_jump(32'h102C, 1'b0));

        // mret target with low bits masked.
        drive(1'b1, 32'h520, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(21, o_mret(), o_mret());
        drive(1'b0, 32'h524, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(22, o_jump(32'h774, 1'b1), o_jump(32'h774, 1'b1));

        // Reset during TRAP_JUMP aborts; held interrupt retriggers afterwards.
        mtvec = 32'h200;
        drive(1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(23, o_entry(32'h600, 32'h8000_0007), o_entry(32'h600, 32'h8000_0007));
        rst_n = 1'b0;
        drive(1'b1, 32'h604, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(24, o_jump(32'h200, 1'b0), o_jump(32'h21C, 1'b0));
        step(25, o_idle(), o_idle());
        rst_n = 1'b1;
        step(26, o_entry(32'h604, 32'h8000_0007), o_entry(32'h604, 32'h8000_0007));
        drive(1'b0, 32'h608, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(27, o_jump(32'h200, 1'b0), o_jump(32'h21C, 1'b0));
        drive(1'b0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(28, o_idle(), o_idle());

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        n_checks = n_checks + 1;
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
